// File: rtl/dmem_sized.sv
// dmem_sized: byte/halfword/word data memory with req/ready/done handshake,
// configurable wait-state latency, sign/zero-extended loads and alignment
// error reporting. Optional per-byte even parity is enabled by defining
// the macro DMEM_PARITY_EN.
module dmem_sized #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic        perr_inj,
  output logic        ready,
  output logic        done,
  output logic [31:0] rd,
  output logic        adel,
  output logic        ades,
  output logic        perr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  // Misalignment rule: halfwords need even, words need 4-byte aligned, size 11 is never legal.
  function automatic logic f_misaligned(input logic [1:0] sz, input logic [1:0] off);
    logic m;
    case (sz)
      2'b00:   m = 1'b0;
      2'b01:   m = off[0];
      2'b10:   m = (off != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  // Little-endian byte lanes touched by an access of the given size and offset.
  function automatic logic [3:0] f_lanes(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] l;
    case (sz)
      2'b00:   l = 4'b0001 << off;
      2'b01:   l = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   l = 4'b1111;
      default: l = 4'b0000;
    endcase
    return l;
  endfunction

  state_t          r_state, w_next;
  logic [3:0]      r_cnt, w_cnt_next;
  logic            r_ready;
  logic            w_accept, w_commit;

  logic            r_we, r_uns, r_pinj;
  logic [1:0]      r_size, r_off;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wd;

  logic            w_c_we, w_c_uns, w_c_pinj, w_c_mis;
  logic [1:0]      w_c_size, w_c_off;
  logic [AW-1:0]   w_c_idx;
  logic [31:0]     w_c_wd;

  logic [31:0]     r_mem [DEPTH];
  logic [31:0]     w_rword, w_wdata, w_load;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [3:0]      w_lanes;
  logic            w_wr, w_rdok, w_perr_hit;

  logic            r_done, r_adel, r_ades, r_perr;
  logic [31:0]     r_rd;

  assign w_accept = req & r_ready & ~reset;

  // With zero latency the access commits on the acceptance edge, so it uses the live inputs.
  assign w_c_we   = (LATENCY == 0) ? we           : r_we;
  assign w_c_uns  = (LATENCY == 0) ? uns          : r_uns;
  assign w_c_pinj = (LATENCY == 0) ? perr_inj     : r_pinj;
  assign w_c_size = (LATENCY == 0) ? size         : r_size;
  assign w_c_off  = (LATENCY == 0) ? a[1:0]       : r_off;
  assign w_c_idx  = (LATENCY == 0) ? a[AW+1:2]    : r_idx;
  assign w_c_wd   = (LATENCY == 0) ? wd           : r_wd;
  assign w_c_mis  = f_misaligned(w_c_size, w_c_off);

  assign w_lanes  = f_lanes(w_c_size, w_c_off);
  assign w_wr     = w_commit & ~w_c_mis & w_c_we;
  assign w_rdok   = w_commit & ~w_c_mis & ~w_c_we;
  assign w_rword  = r_mem[w_c_idx];
  assign w_byte   = w_rword[{w_c_off, 3'b000} +: 8];
  assign w_half   = w_c_off[1] ? w_rword[31:16] : w_rword[15:0];

  // Next-state, wait counter and commit strobe.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_commit   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 0) begin
            w_commit = 1'b1;
          end else begin
            w_next     = S_BUSY;
            w_cnt_next = LAT_M1;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_commit = 1'b1;
          w_next   = S_IDLE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Store data replicated across lanes and load data extraction/extension.
  always_comb begin
    w_wdata = w_c_wd;
    w_load  = w_rword;
    case (w_c_size)
      2'b00: begin
        w_wdata = {4{w_c_wd[7:0]}};
        w_load  = {{24{~w_c_uns & w_byte[7]}}, w_byte};
      end
      2'b01: begin
        w_wdata = {2{w_c_wd[15:0]}};
        w_load  = {{16{~w_c_uns & w_half[15]}}, w_half};
      end
      default: begin
        w_wdata = w_c_wd;
        w_load  = w_rword;
      end
    endcase
  end

  // FSM state, wait counter and registered ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_ready <= (w_next == S_IDLE);
    end
  end

  // Capture the request fields at the acceptance edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_uns  <= 1'b0;
      r_pinj <= 1'b0;
      r_size <= 2'b00;
      r_off  <= 2'b00;
      r_idx  <= '0;
      r_wd   <= 32'd0;
    end else if (w_accept) begin
      r_we   <= we;
      r_uns  <= uns;
      r_pinj <= perr_inj;
      r_size <= size;
      r_off  <= a[1:0];
      r_idx  <= a[AW+1:2];
      r_wd   <= wd;
    end
  end

  // Byte-lane RAM write at the commit edge; RAM contents are not reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lanes[i]) r_mem[w_c_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

`ifdef DMEM_PARITY_EN
  logic [3:0] r_par [DEPTH];

  // Even parity of each byte of a word.
  function automatic logic [3:0] f_par(input logic [31:0] w);
    return {^w[31:24], ^w[23:16], ^w[15:8], ^w[7:0]};
  endfunction

  // Parity written alongside data, optionally corrupted for error injection.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lanes[i]) r_par[w_c_idx][i] <= (^w_wdata[8*i +: 8]) ^ w_c_pinj;
      end
    end
  end

  assign w_perr_hit = |((f_par(w_rword) ^ r_par[w_c_idx]) & w_lanes);
`else
  assign w_perr_hit = 1'b0;
`endif

  // Completion pulse, error flags and load data, all registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done <= 1'b0;
      r_adel <= 1'b0;
      r_ades <= 1'b0;
      r_perr <= 1'b0;
      r_rd   <= 32'd0;
    end else begin
      r_done <= w_commit;
      r_adel <= w_commit & w_c_mis & ~w_c_we;
      r_ades <= w_commit & w_c_mis & w_c_we;
      r_perr <= w_rdok & w_perr_hit;
      if (w_rdok) r_rd <= w_load;
    end
  end

  assign ready = r_ready;
  assign done  = r_done;
  assign rd    = r_rd;
  assign adel  = r_adel;
  assign ades  = r_ades;
  assign perr  = r_perr;

endmodule

// File: tb/tb_dmem_sized.sv
// Bench for dmem_sized: three instances (LATENCY 0, 3, 5) share the request
// inputs and reset; a byte-array reference model predicts every result.
module tb_dmem_sized;

`ifdef DMEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, req, we, uns, perr_inj;
  logic [1:0]  size;
  logic [31:0] a, wd;
  logic        rdy [3], dn [3], adl [3], ads [3], pe [3];
  logic [31:0] rdo [3];

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0]  mb   [3][256];
  bit          bad  [3][256];
  logic [31:0] rd_m [3];

  // values seen in each instance's done cycle
  logic [31:0] g_rd [3];
  logic        g_adel [3], g_ades [3], g_perr [3];

  always #5 clk = ~clk;

  dmem_sized #(.DEPTH(64), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .uns(uns),
    .a(a), .wd(wd), .perr_inj(perr_inj), .ready(rdy[0]), .done(dn[0]),
    .rd(rdo[0]), .adel(adl[0]), .ades(ads[0]), .perr(pe[0]));
  dmem_sized #(.DEPTH(64), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .uns(uns),
    .a(a), .wd(wd), .perr_inj(perr_inj), .ready(rdy[1]), .done(dn[1]),
    .rd(rdo[1]), .adel(adl[1]), .ades(ads[1]), .perr(pe[1]));
  dmem_sized #(.DEPTH(64), .LATENCY(5)) u_l5 (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .uns(uns),
    .a(a), .wd(wd), .perr_inj(perr_inj), .ready(rdy[2]), .done(dn[2]),
    .rd(rdo[2]), .adel(adl[2]), .ades(ads[2]), .perr(pe[2]));

  function automatic int lat(input int i);
    case (i)
      0:       return 0;
      1:       return 3;
      default: return 5;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference: memory as a flat byte array, address wraps at 256 bytes.
  task automatic model_apply(input int i, input bit w, input bit [1:0] sz, input bit un,
                             input bit [31:0] ad, input bit [31:0] d, input bit inj,
                             output bit e_adel, output bit e_ades, output bit e_perr);
    int n;
    int base;
    bit mis;
    bit pbad;
    logic [31:0] v;
    logic [31:0] ones;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = int'(ad[7:0]);
    mis = (sz == 2'd3) || ((base % n) != 0);
    e_adel = 1'b0; e_ades = 1'b0; e_perr = 1'b0;
    if (mis) begin
      e_adel = !w;
      e_ades = w;
    end else if (w) begin
      for (int j = 0; j < n; j++) begin
        mb[i][base + j]  = 8'((d >> (8 * j)) & 32'hff);
        bad[i][base + j] = inj;
      end
    end else begin
      v = 32'd0;
      pbad = 1'b0;
      for (int j = 0; j < n; j++) begin
        v = v | (32'(mb[i][base + j]) << (8 * j));
        pbad = pbad | bad[i][base + j];
      end
      ones = 32'hffffffff;
      if (!un && n < 4 && v[8 * n - 1]) v = v | (ones << (8 * n));
      rd_m[i] = v;
      e_perr = PAR && pbad;
    end
  endtask

  // One request presented to all instances; every output checked for six cycles.
  task automatic txn(input bit w, input bit [1:0] sz, input bit un, input bit [31:0] ad,
                     input bit [31:0] d, input bit inj, input string tag);
    bit ea [3], es [3], ep [3];
    logic [31:0] old [3];
    bit ed, er;
    for (int i = 0; i < 3; i++) begin
      old[i] = rd_m[i];
      model_apply(i, w, sz, un, ad, d, inj, ea[i], es[i], ep[i]);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s.i%0d ready_before", tag, i), {31'd0, rdy[i]}, 32'd1);
    we = w; size = sz; uns = un; a = ad; wd = d; perr_inj = inj; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        ed = (k == lat(i) + 1);
        er = (k >= lat(i) + 1);
        chk($sformatf("%s.i%0d.c%0d status", tag, i, k),
            {27'd0, dn[i], rdy[i], adl[i], ads[i], pe[i]},
            {27'd0, ed, er, ed & ea[i], ed & es[i], ed & ep[i]});
        chk($sformatf("%s.i%0d.c%0d rd", tag, i, k), rdo[i], er ? rd_m[i] : old[i]);
        if (ed) begin
          g_rd[i] = rdo[i]; g_adel[i] = adl[i]; g_ades[i] = ads[i]; g_perr[i] = pe[i];
        end
      end
    end
  endtask

  typedef struct {
    bit        w;
    bit [1:0]  sz;
    bit        un;
    bit [31:0] ad;
    bit [31:0] d;
    bit        inj;
    bit [31:0] e_rd;
    bit        e_adel;
    bit        e_ades;
    bit        e_perr;
  } vec_t;

  vec_t tbl [21];

  initial begin
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'h8badf00d, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        1'b0, 32'h8badf00d, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h13,  32'h000000f0, 1'b0, 32'h8badf00d, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        1'b0, 32'hfffffff0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        1'b0, 32'h000000f0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        1'b0, 32'hf0adf00d, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 2'd1, 1'b0, 32'h22,  32'h00001234, 1'b0, 32'hf0adf00d, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h21,  32'h0,        1'b0, 32'hf0adf00d, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 2'd1, 1'b1, 32'h22,  32'h0,        1'b0, 32'h00001234, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 2'd2, 1'b0, 32'h00,  32'h11223344, 1'b0, 32'h00001234, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 2'd2, 1'b0, 32'h02,  32'hdeadbeef, 1'b0, 32'h00001234, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h00,  32'h0,        1'b0, 32'h11223344, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 2'd2, 1'b0, 32'h100, 32'hcafe0001, 1'b0, 32'h11223344, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 2'd2, 1'b0, 32'h000, 32'h0,        1'b0, 32'hcafe0001, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 2'd1, 1'b0, 32'h12,  32'h0,        1'b0, 32'hfffff0ad, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 2'd3, 1'b0, 32'h00,  32'h0,        1'b0, 32'hfffff0ad, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 2'd3, 1'b0, 32'h04,  32'h5a5a5a5a, 1'b0, 32'hfffff0ad, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 2'd2, 1'b0, 32'h08,  32'h0a0b0c0d, 1'b1, 32'hfffff0ad, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 2'd0, 1'b1, 32'h09,  32'h0,        1'b0, 32'h0000000c, 1'b0, 1'b0, PAR};
    tbl[19] = '{1'b1, 2'd2, 1'b0, 32'h0c,  32'h55aa55aa, 1'b0, 32'h0000000c, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 2'd2, 1'b0, 32'h0c,  32'h0,        1'b0, 32'h55aa55aa, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 3; i++) rd_m[i] = 32'd0;
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0;
    a = 32'd0; wd = 32'd0; perr_inj = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset.i%0d status", i),
          {27'd0, dn[i], rdy[i], adl[i], ads[i], pe[i]}, {27'd0, 5'b01000});
      chk($sformatf("reset.i%0d rd", i), rdo[i], 32'd0);
    end

    // directed vectors
    for (int t = 0; t < 21; t++) begin
      txn(tbl[t].w, tbl[t].sz, tbl[t].un, tbl[t].ad, tbl[t].d, tbl[t].inj, $sformatf("vec%0d", t));
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("vec%0d.i%0d rd_exp", t, i), g_rd[i], tbl[t].e_rd);
        chk($sformatf("vec%0d.i%0d flags_exp", t, i),
            {29'd0, g_adel[i], g_ades[i], g_perr[i]},
            {29'd0, tbl[t].e_adel, tbl[t].e_ades, tbl[t].e_perr});
      end
    end

    // reset two edges after acceptance discards the pending store
    txn(1'b1, 2'd2, 1'b0, 32'h40, 32'haaaa5555, 1'b0, "rst_pre");
    begin
      bit x0, x1, x2;
      @(negedge clk);
      we = 1'b1; size = 2'd2; uns = 1'b0; a = 32'h40; wd = 32'h12345678; perr_inj = 1'b0; req = 1'b1;
      model_apply(0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678, 1'b0, x0, x1, x2);
      @(posedge clk);
      #1 req = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      for (int i = 0; i < 3; i++) rd_m[i] = 32'd0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("rst_mid.i%0d.c%0d status", i, k),
              {27'd0, dn[i], rdy[i], adl[i], ads[i], pe[i]}, {27'd0, 5'b01000});
          chk($sformatf("rst_mid.i%0d.c%0d rd", i, k), rdo[i], 32'd0);
        end
      end
    end
    txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0, "rst_post");
    chk("rst_post.l0 committed", g_rd[0], 32'h12345678);
    chk("rst_post.l3 old data", g_rd[1], 32'haaaa5555);
    chk("rst_post.l5 old data", g_rd[2], 32'haaaa5555);

    // fill every word so random loads read defined data
    for (int w = 0; w < 64; w++)
      txn(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 1'b0, "fill");

    // randomized traffic, mostly aligned
    for (int r = 0; r < 150; r++) begin
      bit [31:0] ra;
      bit [1:0]  rs;
      ra = $urandom;
      rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (rs == 2'd1) ra[0] = 1'b0;
        else if (rs == 2'd2) ra[1:0] = 2'b00;
      end
      txn(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom,
          1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_sized.md
Name: dmem_sized

Overview:
- Parametrised successor to the single-cycle word data memory.
- Adds byte/halfword/word loads and stores with per-lane write enables, sign or zero extension, alignment-error detection and a configurable wait-state latency.
- Uses a req/ready/done handshake so the CPU can stall on slow memory.
- Sits between the MIPS core's memory stage and on-chip data RAM.

Parameters:
- DEPTH, 64, number of 32-bit words; must be a power of 2, minimum 4.
- LATENCY, 1, wait cycles between acceptance and completion; range 0..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request valid.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- uns  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- a  in  32  byte address.
- wd  in  32  store data, right-justified: byte in [7:0], halfword in [15:0].
- perr_inj  in  1  parity error injection (see Optional Feature).
- ready  out  1  block can accept a request this cycle.
- done  out  1  one-cycle completion pulse.
- rd  out  32  registered, extended load data.
- adel  out  1  load address error; valid with done.
- ades  out  1  store address error; valid with done.
- perr  out  1  parity error; valid with done.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; ready = 1 once reset deasserts.
  - done, rd, adel, ades, perr = 0; wait counter = 0.
  - RAM contents are not reset.
- States: IDLE and BUSY.
  - ready = 1 only in IDLE.
  - A request is accepted at the edge where req & ready; we, size, uns, a and wd are captured into registers at that edge.
  - req while ready = 0 is ignored, not queued.
- Transitions and timing:
  - Acceptance with LATENCY = 0: stay in IDLE. The access commits at the acceptance edge and done = 1 in the following cycle.
  - Acceptance with LATENCY > 0: go to BUSY and load counter = LATENCY - 1.
  - In BUSY the counter decrements each edge. The edge at which counter = 0 commits the access and returns to IDLE.
  - done = 1 during the cycle after the commit edge. done is high for exactly one cycle per request.
  - ready is high during the done cycle, so back-to-back throughput is one request per LATENCY+1 cycles.
- Word index = a[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Byte lanes are little-endian: byte offset a[1:0] = 0 maps to bits [7:0].
- Alignment check at acceptance:
  - Misaligned if size = 01 with a[0] = 1, size = 10 with a[1:0] != 0, or size = 11.
  - A misaligned request still follows the normal latency. At commit there is no RAM write and rd keeps its previous value.
  - done pulses with adel = we ? 0 : 1 and ades = we.
- Stores:
  - Lane enables are derived from size and a[1:0].
  - wd is replicated to the selected lanes; unselected lanes are unchanged.
  - rd is unchanged by a store.
- Loads:
  - Select the byte or halfword from the addressed lane and extend it to 32 bits per uns.
  - rd is updated at the commit edge and holds until the next successful load.
- Error outputs: adel, ades and perr are 0 whenever done = 0.
- Reset mid-operation: the pending request is discarded, with no RAM write and no done pulse.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- When defined:
  - Each word has 4 stored even-parity bits, one per byte.
  - A store writes parity for its written lanes, inverted on those lanes when perr_inj = 1 at acceptance.
  - A load checks only the accessed lanes; any mismatch gives perr = 1 with done.
  - The load data is still returned.
- When undefined: no parity storage, perr is tied to 0 and perr_inj is ignored.

Test Plan:
- LATENCY = 0, sw wd = 0x8badf00d at a = 0x10, then lw a = 0x10 → done in the cycle after each acceptance; rd = 0x8badf00d; ready never drops.
- LATENCY = 3, sb wd = 0x000000f0 at a = 0x13, then lb a = 0x13 → ready low for 3 cycles after each acceptance; done 4 cycles after acceptance; rd = 0xfffffff0. lbu at the same address → rd = 0x000000f0. Word 0x10 has only bits [31:24] changed.
- sh a = 0x22 wd = 0x1234 then lh a = 0x21 → store commits normally; the load gives done with adel = 1, rd unchanged. sw a = 0x02 → ades = 1 and RAM is unmodified (verified by lw a = 0x00).
- DEPTH = 64: sw a = 0x100 wd = 0xcafe0001 → lw a = 0x000 returns 0xcafe0001 (wrap-around).
- LATENCY = 5: assert reset 2 cycles after accepting sw a = 0x40 → no done pulse; lw a = 0x40 after reset returns the old contents.
- DMEM_PARITY_EN: sw a = 0x8 with perr_inj = 1 → lbu a = 0x9 gives perr = 1; a clean sw then lw at a = 0xc gives perr = 0.
